// File: rtl/seq_alu_if.sv
// Operand/result bundle for seq_alu.
// master: the side that issues operations and collects results.
// slave:  the ALU itself.
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [2:0]       alu_op;
    logic             out_valid;
    logic [WIDTH-1:0] alu_out;
    logic             z;
    logic             div_zero;

    modport master (
        output in_valid, in1, in2, alu_op,
        input  in_ready, out_valid, alu_out, z, div_zero
    );

    modport slave (
        input  in_valid, in1, in2, alu_op,
        output in_ready, out_valid, alu_out, z, div_zero
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: sequential unsigned ALU with a valid/ready operand port.
// Add, subtract (in2-in1), multiply (low half) and pass-through finish
// one cycle after accept.
// Define SEQ_ALU_DIV_EN to build the multi-cycle restoring divider for
// opcode 3; without it opcode 3 completes in one cycle with alu_out=0 and
// div_zero=1, and the block is always ready.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    seq_alu_if.slave  bus
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [2:0]       OP_DIV   = 3'd3;

    logic [WIDTH-1:0] fast_result;
    logic             out_valid_q;
    logic [WIDTH-1:0] alu_out_q;
    logic             z_q;
    logic             div_zero_q;

    // Result of every single-cycle opcode, taken straight from the inputs.
    always_comb begin
        fast_result = bus.in1 + bus.in2;
        case (bus.alu_op)
            3'd1:    fast_result = bus.in2 - bus.in1;
            3'd2:    fast_result = bus.in1 * bus.in2;
            3'd4:    fast_result = bus.in2;
            default: fast_result = bus.in1 + bus.in2;
        endcase
    end

`ifdef SEQ_ALU_DIV_EN

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;

    state_t           state;
    logic             in_ready_q;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH:0]   rem_sub;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The remainder is
    // always below the divisor afterwards, so WIDTH bits hold it.
    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, divisor});
        rem_sub   = rem_shift - {1'b0, divisor};
        rem_next  = rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {quo[WIDTH-2:0], rem_ge};
    end

    // Control FSM plus registered result/flags; a divide occupies DIV for
    // WIDTH cycles and writes its quotient on the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            z_q         <= 1'b1;
            div_zero_q  <= 1'b0;
            quo         <= '0;
            rem         <= '0;
            divisor     <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    if (bus.in_valid) begin
                        if (bus.alu_op == OP_DIV) begin
                            if (bus.in2 == '0) begin
                                alu_out_q   <= ALL_ONES;
                                z_q         <= 1'b0;
                                div_zero_q  <= 1'b1;
                                out_valid_q <= 1'b1;
                            end else begin
                                state      <= DIV;
                                in_ready_q <= 1'b0;
                                quo        <= bus.in1;
                                rem        <= '0;
                                divisor    <= bus.in2;
                                count      <= '0;
                            end
                        end else begin
                            alu_out_q   <= fast_result;
                            z_q         <= (fast_result == '0);
                            div_zero_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    out_valid_q <= 1'b0;
                    quo         <= quo_next;
                    rem         <= rem_next;
                    count       <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state       <= IDLE;
                        in_ready_q  <= 1'b1;
                        alu_out_q   <= quo_next;
                        z_q         <= (quo_next == '0);
                        div_zero_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;

`else

    // Single-cycle datapath; opcode 3 reports divide-unsupported as a
    // zero result with div_zero raised.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            z_q         <= 1'b1;
            div_zero_q  <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                if (bus.alu_op == OP_DIV) begin
                    alu_out_q  <= '0;
                    z_q        <= 1'b1;
                    div_zero_q <= 1'b1;
                end else begin
                    alu_out_q  <= fast_result;
                    z_q        <= (fast_result == '0);
                    div_zero_q <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready = 1'b1;

`endif

    assign bus.out_valid = out_valid_q;
    assign bus.alu_out   = alu_out_q;
    assign bus.z         = z_q;
    assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: directed cases followed by random traffic, all
// checked every cycle against a cycle-level behavioural model.
// Honours SEQ_ALU_DIV_EN the same way the design does.
module tb_seq_alu;

    localparam int WIDTH = 16;
    localparam longint unsigned MASK = (64'd1 << WIDTH) - 1;

    logic clk = 1'b0;
    logic reset;

    int tests = 0;
    int fails = 0;

    // Reference model state: what each output should show after the edge.
    bit              m_ready;
    bit              m_valid;
    bit              m_z;
    bit              m_dz;
    longint unsigned m_out;
    longint unsigned m_pend;
    int              m_left;

    seq_alu_if #(.WIDTH(WIDTH)) bus ();

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Record a completed operation in the model.
    task automatic modelComplete(input longint unsigned res, input bit dz);
        m_valid = 1'b1;
        m_out   = res & MASK;
        m_z     = (m_out == 0);
        m_dz    = dz;
    endtask

    // Drive one cycle of inputs, advance the model across the coming edge,
    // then compare every output half a cycle after that edge.
    task automatic applyStimulus(input bit rst_in, input bit v,
                                 input longint unsigned a, input longint unsigned b,
                                 input int unsigned op);
        a = a & MASK;
        b = b & MASK;
        reset        = rst_in;
        bus.in_valid = v;
        bus.in1      = a[WIDTH-1:0];
        bus.in2      = b[WIDTH-1:0];
        bus.alu_op   = op[2:0];

        if (rst_in) begin
            m_ready = 1'b1; m_valid = 1'b0; m_out = 0; m_z = 1'b1; m_dz = 1'b0;
            m_left  = 0;    m_pend  = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                modelComplete(m_pend, 1'b0);
                m_ready = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end else if (v) begin
            case (op)
                1:       modelComplete(b - a, 1'b0);
                2:       modelComplete(a * b, 1'b0);
                4:       modelComplete(b, 1'b0);
                3: begin
`ifdef SEQ_ALU_DIV_EN
                    if (b == 0) begin
                        modelComplete(MASK, 1'b1);
                    end else begin
                        m_pend  = a / b;
                        m_left  = WIDTH;
                        m_ready = 1'b0;
                        m_valid = 1'b0;
                    end
`else
                    modelComplete(0, 1'b1);
`endif
                end
                default: modelComplete(a + b, 1'b0);
            endcase
        end else begin
            m_valid = 1'b0;
        end

        @(negedge clk);
        checkOutput("in_ready",  {31'd0, bus.in_ready},  {31'd0, m_ready});
        checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        checkOutput("alu_out",   32'(bus.alu_out),       m_out[31:0]);
        checkOutput("z",         {31'd0, bus.z},         {31'd0, m_z});
        checkOutput("div_zero",  {31'd0, bus.div_zero},  {31'd0, m_dz});
    endtask

    // Directed corner cases, then randomized traffic with occasional resets.
    initial begin
        m_ready = 1'b1; m_valid = 1'b0; m_out = 0; m_z = 1'b1; m_dz = 1'b0;
        m_left  = 0;    m_pend  = 0;

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 5, 5, 0);
        applyStimulus(0, 0, 0, 0, 0);

        applyStimulus(0, 1, 'h7FFF, 'h0001, 0);
        applyStimulus(0, 0, 0, 0, 0);

        applyStimulus(0, 1, 'h1234, 'h1234, 1);
        applyStimulus(0, 1, 5, 3, 1);
        applyStimulus(0, 0, 0, 0, 0);

        applyStimulus(0, 1, 'h0100, 'h0100, 2);
        applyStimulus(0, 1, 0, 'hABCD, 4);
        applyStimulus(0, 0, 0, 0, 0);

        applyStimulus(0, 1, 100, 7, 3);
        for (int i = 0; i < 20; i++)
            applyStimulus(0, i[0], 'h1111 + i, 'h0202, 0);
        applyStimulus(0, 0, 0, 0, 0);

        applyStimulus(0, 1, 'h0042, 0, 3);
        applyStimulus(0, 0, 0, 0, 0);

        applyStimulus(0, 1, 1000, 3, 3);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 9, 9, 0);
        for (int i = 0; i < 20; i++)
            applyStimulus(0, 0, 0, 0, 0);

        applyStimulus(0, 1, 'hFFFF, 1, 3);
        for (int i = 0; i < 18; i++)
            applyStimulus(0, 0, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            longint unsigned a;
            longint unsigned b;
            a = longint'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom);
            if ($urandom_range(0, 5) == 0)
                b = b & 'h000F;
            applyStimulus(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
                          a, b, $urandom_range(0, 7));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 16, operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operands and opcode present this cycle.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 in1  input  WIDTH  operand A.
REQ-008 in2  input  WIDTH  operand B.
REQ-009 alu_op  input  3  opcode.
REQ-010 out_valid  output  1  one-cycle pulse: result and flags are new.
REQ-011 alu_out  output  WIDTH  registered result.
REQ-012 z  output  1  registered zero flag: alu_out equals 0.
REQ-013 div_zero  output  1  registered divide-by-zero flag.

Function
REQ-014 Accept SHALL occur on a rising edge where in_valid and in_ready are both 1; operands and opcode SHALL be captured on that edge.
REQ-015 Opcodes SHALL be:
  - 0: in1+in2
  - 1: in2-in1
  - 2: in1*in2, low WIDTH bits
  - 3: in1/in2, unsigned quotient
  - 4: in2
  - 5-7: in1+in2
  - All arithmetic is unsigned and modulo 2^WIDTH; carries and overflow are discarded.
REQ-016 FSM states SHALL be IDLE and DIV; in_ready SHALL be 1 exactly when the state is IDLE.
REQ-017 Opcodes other than 3 SHALL complete with 1-cycle latency:
  - Result is registered on the accept edge.
  - out_valid is high for the following cycle.
  - State remains IDLE.
REQ-018 Opcode 3 with in2 != 0 SHALL move IDLE->DIV.
  - Restoring shift-subtract, one quotient bit per cycle, for WIDTH cycles.
  - Then return to IDLE with result registered.
  - out_valid is high WIDTH+1 edges after the accept edge.
REQ-019 Opcode 3 with in2 == 0 SHALL NOT enter DIV.
  - alu_out is all ones and div_zero = 1.
  - 1-cycle latency.
REQ-020 div_zero SHALL be 0 for every other completed operation; z SHALL be computed from the value registered into alu_out on the same edge.
REQ-021 alu_out, z and div_zero SHALL hold their last values until the next completion; out_valid SHALL never be high for more than one consecutive cycle per operation.
REQ-022 in_valid while in_ready=0 SHALL be ignored: no capture, no queueing.
REQ-023 Back-to-back accepts SHALL be supported: a new accept may occur in the same cycle out_valid is high, giving one result per cycle for 1-cycle ops.

Reset
REQ-024 When reset is 1 on an edge, the block SHALL set:
  - state = IDLE, in_ready = 1
  - out_valid = 0, alu_out = 0, z = 1, div_zero = 0
  - All divider working registers cleared.
REQ-025 Reset SHALL take priority over accept.
REQ-026 Reset during DIV SHALL abort the divide and produce no out_valid for it.

Configuration
REQ-027 Macro SEQ_ALU_DIV_EN: when defined, opcode 3 SHALL behave per REQ-018/REQ-019.
REQ-028 Without SEQ_ALU_DIV_EN:
  - No divider logic and no DIV state.
  - Opcode 3 SHALL complete in 1 cycle with alu_out = 0, z = 1, div_zero = 1.
  - in_ready SHALL be constantly 1 outside reset.

Verification (WIDTH=16, SEQ_ALU_DIV_EN defined unless stated)
REQ-029 Add: op0, in1=0x7FFF, in2=0x0001 -> next cycle out_valid=1, alu_out=0x8000, z=0, div_zero=0.
REQ-030 Sub and zero flag: op1, in1=in2=0x1234 -> alu_out=0x0000, z=1; op1, in1=5, in2=3 -> alu_out=0xFFFE.
REQ-031 Mul truncation: op2, 0x0100*0x0100 -> alu_out=0x0000, z=1; then back-to-back op4, in2=0xABCD on the next cycle -> alu_out=0xABCD one cycle later.
REQ-032 Divide:
  - op3, in1=100, in2=7.
  - in_ready=0 for 16 cycles; in_valid pulses during that window are ignored.
  - out_valid 17 edges after accept with alu_out=14, div_zero=0.
REQ-033 Divide by zero: op3, in1=0x0042, in2=0 -> next cycle alu_out=0xFFFF, div_zero=1, z=0, in_ready stays 1.
REQ-034 Reset mid-divide:
  - Assert reset 5 cycles into a divide.
  - Outputs return to reset values, in_ready=1 next cycle, and no out_valid for the aborted op.
  - Without SEQ_ALU_DIV_EN, op3 gives alu_out=0, div_zero=1 in 1 cycle.
